// File: rtl/uart_boot_pkg.sv
// Shared constants, state encodings and helpers for the UART program loader.
package uart_boot_pkg;

    localparam int unsigned PAR_NONE  = 0;
    localparam int unsigned PAR_EVEN  = 1;
    localparam int unsigned PAR_ODD   = 2;
    localparam int unsigned PAR_SPACE = 3;

    localparam logic [31:0] DEF_SYNC_WORD = 32'hF0F0_F0F0;
    localparam logic [31:0] DEF_END_WORD  = 32'h0F0F_0F0F;
    localparam logic [7:0]  DEF_CMD_BYTE  = 8'hC2;

    typedef enum logic [1:0] {ST_HUNT, ST_CMD, ST_LOAD, ST_PEND} ld_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_e;

    // Rounded clocks per oversample tick, never below one.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned ovs);
        int unsigned d;
        d = (clk_hz + (baud * ovs) / 2) / (baud * ovs);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_boot_loader_rx.sv
// Oversampled UART receiver: one byte per frame with parity/stop checking.
module uart_rx_os
    import uart_boot_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY     = PAR_SPACE
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);

    rx_state_e        state_q;
    logic [1:0]       sync_q;
    logic [DIV_W-1:0] div_q;
    logic [OS_W-1:0]  os_q;
    logic [2:0]       bit_q;
    logic [7:0]       data_q;
    logic [7:0]       byte_q;
    logic             par_bad_q;
    logic             valid_q;
    logic             ferr_q;
    logic             rxd_s;
    logic             tick;
    logic             exp_par;

    assign rxd_s   = sync_q[1];
    assign tick    = (div_q == DIV_LAST);
    assign exp_par = (PARITY == PAR_EVEN) ? ^data_q :
                     (PARITY == PAR_ODD)  ? ~^data_q :
                     (PARITY == PAR_SPACE) ? 1'b0 : 1'b0;

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RX_IDLE;
            sync_q    <= 2'b11;
            div_q     <= '0;
            os_q      <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            byte_q    <= '0;
            par_bad_q <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rxd_i};
            valid_q <= 1'b0;
            if (state_q == RX_IDLE) begin
                div_q     <= '0;
                os_q      <= '0;
                bit_q     <= '0;
                par_bad_q <= 1'b0;
                if (!rxd_s) state_q <= RX_START;
            end else begin
                div_q <= tick ? '0 : div_q + DIV_W'(1);
                if (tick) os_q <= os_q + OS_W'(1);
                // Every sample point realigns the oversample counter to the bit centre.
                case (state_q)
                    RX_START: if (tick && os_q == OS_HALF) begin
                        os_q    <= '0;
                        state_q <= rxd_s ? RX_IDLE : RX_DATA;
                    end
                    RX_DATA: if (tick && os_q == OS_LAST) begin
                        os_q   <= '0;
                        data_q <= {rxd_s, data_q[7:1]};
                        bit_q  <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= (PARITY != PAR_NONE) ? RX_PAR : RX_STOP;
                    end
                    RX_PAR: if (tick && os_q == OS_LAST) begin
                        os_q      <= '0;
                        par_bad_q <= (rxd_s != exp_par);
                        state_q   <= RX_STOP;
                    end
                    RX_STOP: if (tick && os_q == OS_LAST) begin
                        byte_q  <= data_q;
                        valid_q <= 1'b1;
                        ferr_q  <= par_bad_q | ~rxd_s;
                        state_q <= RX_IDLE;
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Serial program loader: parses sync/command/program/end framing from the UART
// and writes program words to instruction memory while holding the CPU in reset.
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned BAUD          = 9600,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned PARITY        = PAR_SPACE,
    parameter int unsigned ADDR_W        = 12,
    parameter logic [31:0] SYNC_WORD     = DEF_SYNC_WORD,
    parameter logic [31:0] END_WORD      = DEF_END_WORD,
    parameter logic [7:0]  CMD_BYTE      = DEF_CMD_BYTE,
    parameter int unsigned TIMEOUT_BYTES = 4,
    parameter logic        HOLD_AT_RESET = 1'b1
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic              rxd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned DIV        = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned FRAME_BITS = (PARITY == PAR_NONE) ? 10 : 11;
    localparam int unsigned TO_LIMIT   = TIMEOUT_BYTES * FRAME_BITS * OVERSAMPLE * DIV;
    localparam int unsigned TO_W       = $clog2(TO_LIMIT + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_LIMIT - 1);
    localparam logic [31:0]       TERM_WORD = {CMD_BYTE, 24'h0};
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx_os #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE),
        .PARITY    (PARITY)
    ) u_rx (
        .clk_i       (CLK100MHZ),
        .rst_ni      (CPU_RESETN),
        .rxd_i       (rxd),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_ferr)
    );

    ld_state_e         state_q;
    logic [23:0]       shift_q;
    logic [1:0]        byte_cnt_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              ovf_q;
    logic              flush_q;
    logic [31:0]       flush_data_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              error_q;
    logic [ADDR_W:0]   count_q;

    logic [31:0] word;
    logic        word_done;
    logic        wr_req;
    logic [31:0] wr_data;

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = count_q;

    // Write request: pending flush word first, otherwise a completed word in LOAD/PEND.
    always_comb begin
        word      = {shift_q, rx_byte};
        word_done = rx_valid && !rx_ferr && (byte_cnt_q == 2'd3);
        wr_req    = 1'b0;
        wr_data   = word;
        if (flush_q) begin
            wr_req  = 1'b1;
            wr_data = flush_data_q;
        end else if (word_done) begin
            if (state_q == ST_LOAD && word != END_WORD) wr_req = 1'b1;
            if (state_q == ST_PEND && word != TERM_WORD) begin
                wr_req  = 1'b1;
                wr_data = END_WORD;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q      <= ST_HUNT;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            ptr_q        <= '0;
            ovf_q        <= 1'b0;
            flush_q      <= 1'b0;
            flush_data_q <= '0;
            to_cnt_q     <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= HOLD_AT_RESET;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            flush_q  <= 1'b0;

            // Once the top address has been written, later writes only flag an error.
            if (wr_req) begin
                if (ovf_q) begin
                    error_q <= 1'b1;
                end else begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= ptr_q;
                    mem_wdata_q <= wr_data;
                    ptr_q       <= ptr_q + ADDR_W'(1);
                    count_q     <= count_q + (ADDR_W + 1)'(1);
                    if (ptr_q == ADDR_MAX) ovf_q <= 1'b1;
                end
            end

            to_cnt_q <= (state_q == ST_HUNT || rx_valid) ? '0 : to_cnt_q + TO_W'(1);
            if (rx_valid) begin
                shift_q    <= word[23:0];
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end

            case (state_q)
                ST_HUNT: if (rx_valid && word == SYNC_WORD) begin
                    cpu_hold_q <= 1'b1;
                    error_q    <= 1'b0;
                    count_q    <= '0;
                    ovf_q      <= 1'b0;
                    byte_cnt_q <= '0;
                    state_q    <= ST_CMD;
                end
                default: begin
                    if ((rx_valid && rx_ferr) || to_cnt_q == TO_LAST) begin
                        error_q <= 1'b1;
                        shift_q <= '0;
                        state_q <= ST_HUNT;
                    end else if (word_done) begin
                        case (state_q)
                            ST_CMD: begin
                                if (word[31:24] != CMD_BYTE) begin
                                    error_q <= 1'b1;
                                    shift_q <= '0;
                                    state_q <= ST_HUNT;
                                end else begin
                                    ptr_q   <= word[ADDR_W-1:0];
                                    state_q <= ST_LOAD;
                                end
                            end
                            ST_LOAD: if (word == END_WORD) state_q <= ST_PEND;
                            ST_PEND: begin
                                if (word == TERM_WORD) begin
                                    done_q     <= 1'b1;
                                    cpu_hold_q <= 1'b0;
                                    shift_q    <= '0;
                                    state_q    <= ST_HUNT;
                                end else if (word != END_WORD) begin
                                    flush_q      <= 1'b1;
                                    flush_data_q <= word;
                                    state_q      <= ST_LOAD;
                                end
                            end
                            default: state_q <= ST_HUNT;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
